seq_mult_su: RTL and testbench
==============================

// Module: seq_mult_su
//
// PURPOSE
//   Parametrised iterative shift-add multiplier. Next generation of the N=4 load/valid multiplier.
//   Adds a selectable signed (two's complement) or unsigned mode, a busy/start handshake,
//   back-to-back operation and a held result register.
//   Sits between a register-file/ALU issue stage and a result writeback; one product per N+1 cycles.
//
// PARAMETERS
//   N            8    operand width in bits (N >= 2); product width is 2*N
//
// PORTS
//   clk          in   1     rising-edge clock
//   rst_n        in   1     asynchronous active-low reset
//   start        in   1     request; accepted on a rising edge when busy==0
//   signed_mode  in   1     1: a, b, p two's complement; 0: unsigned. Sampled with start
//   a            in   N     multiplicand, sampled on accept edge
//   b            in   N     multiplier, sampled on accept edge
//   busy         out  1     high while iterating; start ignored while high
//   p            out  2N    product; held stable from valid until the next accept edge
//   valid        out  1     one-cycle pulse: p is the product of the last accepted operands
//
// BEHAVIOUR
//   Reset (rst_n low, any time, asynchronous): state=IDLE, busy=0, valid=0, p=0, iteration count=0.
//     An in-flight operation is discarded and no valid is produced.
//   States: IDLE -> RUN on accept. RUN -> DONE after N iterations. DONE -> RUN on accept, else DONE.
//     DONE stays until the next start; IDLE is reached only from reset.
//   Accept: start==1 && busy==0 at edge t0. The edge latches a, b and signed_mode, clears the accumulator,
//     loads count=0 and sets busy=1. p is not cleared; it holds the old value until t0+N.
//   Timing: busy=1 for exactly N cycles (edges t0+1..t0+N perform iterations 0..N-1).
//     At edge t0+N: busy->0, valid->1, p<-final product. At edge t0+N+1: valid->0 unless re-accepted.
//   Back-to-back: start high while valid==1 (busy==0) is accepted at that same edge.
//     valid drops and busy rises at that edge, so throughput is one result per N+1 cycles.
//   Start while busy==1 is ignored; no queueing. a, b and signed_mode changes during RUN have no effect.
//   Datapath: an (N+1)-bit accumulator and the N-bit multiplier register form a 2N+1 shift register.
//     Each iteration examines multiplier bit b[i]. If b[i]==1, add a_ext to the accumulator,
//     where a_ext is a sign-extended (signed) or zero-extended (unsigned) copy of a.
//     In signed mode at i==N-1, subtract a_ext instead (MSB weight -2^(N-1)).
//     The shift is right by one; the new MSB is the carry (unsigned) or the sign bit (signed).
//   Result: p = a*b exact in 2N bits for both modes; no overflow is possible.
//     Unsigned range 0..(2^N-1)^2. Signed extremes: (-2^(N-1))^2 = 2^(2N-2) fits as a positive value.
//   Zero operands follow the normal path; there is no early termination and latency is always N.
//
// STRUCTURE
//   Package mult_pkg holds the state typedef (IDLE/RUN/DONE, 2-bit) and the width function clog2(N)
//     for the iteration counter.
//   Sub-module seq_mult_step: combinational single iteration with inputs acc, a_ext, bit, sub, signed_mode
//     and outputs next_acc and shift_in. It is instantiated once.
//   The top level holds the FSM, counter, operand registers and the p/valid output register.
//
// TESTING (N=8 unless noted)
//   - Unsigned 255*255: start 1 cycle -> busy 8 cycles; valid at t0+8 with p=16'hFE01; p holds after valid.
//   - Signed -128*-128 -> p=16'h4000. Signed -128*127 -> p=16'hC080. Signed -1*1 -> p=16'hFFFF.
//   - Back-to-back: start held high -> valid pulses every 9 cycles. Results 3*15=45, then 0*200=0.
//   - Start pulsed mid-RUN with new operands -> ignored; result equals the first operands.
//     Then rst_n low mid-RUN -> busy=0, valid=0, p=0 immediately, with no valid afterwards.
//   - N=4 instance, unsigned: 2*4=8, 3*15=45, 15*15=225. Signed 4'b1000*4'b1000 -> p=8'h40.
//     A randomized 1000-vector check against a*b in both modes.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: FSM state encoding and counter sizing for the iterative multiplier
package mult_pkg;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/seq_mult_step.sv
// seq_mult_step: one add/subtract-and-shift iteration of the shift-add multiplier
module seq_mult_step #(
    parameter int N = 8
) (
    input  logic [N:0] i_acc,
    input  logic [N:0] i_a_ext,
    input  logic       i_bit,
    input  logic       i_sub,
    input  logic       i_signed_mode,
    output logic [N:0] o_next_acc,
    output logic       o_shift_in
);
    logic [N+1:0] w_acc, w_a, w_sum;
    // One guard bit keeps the sum exact; its top bit becomes the shifted-in MSB
    assign w_acc      = {i_signed_mode & i_acc[N], i_acc};
    assign w_a        = {i_signed_mode & i_a_ext[N], i_a_ext};
    assign w_sum      = w_acc + (i_bit ? (i_sub ? -w_a : w_a) : '0);
    assign o_next_acc = w_sum[N+1:1];
    assign o_shift_in = w_sum[0];
endmodule

// File: rtl/seq_mult_su.sv
// seq_mult_su: signed/unsigned iterative shift-add multiplier, one product per N+1 cycles
module seq_mult_su
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic [2*N-1:0] p,
    output logic           valid
);
    localparam int CW = clog2(N);
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [N:0]    r_acc, w_next_acc;
    logic [N-1:0]  r_mq, r_a;
    logic          r_sgn, w_shift_in, w_last, w_accept;
    assign busy     = r_state == S_RUN;
    assign w_accept = start && !busy;
    assign w_last   = r_cnt == CW'(N - 1);
    // The MSB of the multiplier carries weight -2^(N-1) in signed mode
    seq_mult_step #(.N(N)) u_step (
        .i_acc        (r_acc),
        .i_a_ext      ({r_sgn & r_a[N-1], r_a}),
        .i_bit        (r_mq[0]),
        .i_sub        (r_sgn & w_last),
        .i_signed_mode(r_sgn),
        .o_next_acc   (w_next_acc),
        .o_shift_in   (w_shift_in)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mq    <= '0;
            r_a     <= '0;
            r_sgn   <= 1'b0;
            p       <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (w_accept) begin
                r_state <= S_RUN;
                r_cnt   <= '0;
                r_acc   <= '0;
                r_mq    <= b;
                r_a     <= a;
                r_sgn   <= signed_mode;
            end else if (busy) begin
                r_acc <= w_next_acc;
                r_mq  <= {w_shift_in, r_mq[N-1:1]};
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_state <= S_DONE;
                    valid   <= 1'b1;
                    p       <= {w_next_acc[N-1:0], w_shift_in, r_mq[N-1:1]};
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_mult_su.sv
// tb_seq_mult_su: directed and random checks of N=8 and N=4 multipliers against a cycle-level model
module tb_seq_mult_su;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start[2], sm[2], busy[2], valid[2];
    logic [7:0]  a[2], b[2];
    logic [15:0] p[2], mp[2];
    int          total = 0, bad = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_prod(int nn, bit s, int x, int y);
        int xm = x & ((1 << nn) - 1);
        int ym = y & ((1 << nn) - 1);
        if (s && xm[nn-1]) xm -= 1 << nn;
        if (s && ym[nn-1]) ym -= 1 << nn;
        return 16'((xm * ym) & ((1 << (2 * nn)) - 1));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int NN = (g == 0) ? 8 : 4;
        logic [2*NN-1:0] pw;
        int              m_cnt;
        logic            m_valid;
        logic [15:0]     m_p, m_exp;
        seq_mult_su #(.N(NN)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start[g]),
            .signed_mode(sm[g]),
            .a          (a[g][NN-1:0]),
            .b          (b[g][NN-1:0]),
            .busy       (busy[g]),
            .p          (pw),
            .valid      (valid[g])
        );
        assign p[g]  = 16'(pw);
        assign mp[g] = m_p;
        // Model: accept when idle, busy for NN edges, then a one-cycle valid with the product
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_cnt = 0;
                m_valid = 1'b0;
                m_p = '0;
            end else begin
                m_valid = 1'b0;
                if (start[g] && m_cnt == 0) begin
                    m_exp = exp_prod(NN, sm[g], int'(a[g]), int'(b[g]));
                    m_cnt = NN;
                end else if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_valid = 1'b1;
                        m_p = m_exp;
                    end
                end
            end
        end
        always @(negedge clk) begin
            if (rst_n) begin
                check($sformatf("busy_n%0d", NN), 32'(busy[g]), 32'(m_cnt > 0));
                check($sformatf("valid_n%0d", NN), 32'(valid[g]), 32'(m_valid));
                check($sformatf("p_n%0d", NN), 32'(p[g]), 32'(m_p));
            end
        end
    end

    task automatic run(int g, bit s, logic [7:0] x, logic [7:0] y, logic [15:0] expv, string nm);
        int n = 0;
        @(negedge clk);
        start[g] = 1'b1; sm[g] = s; a[g] = x; b[g] = y;
        @(negedge clk);
        start[g] = 1'b0; sm[g] = ~s; a[g] = 8'($urandom); b[g] = 8'($urandom);
        while (!valid[g] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, " latency"}, 32'(n), 32'(g == 0 ? 8 : 4));
        check({nm, " p"}, 32'(p[g]), 32'(expv));
        check({nm, " model"}, 32'(mp[g]), 32'(expv));
        @(negedge clk);
        check({nm, " hold"}, 32'(p[g]), 32'(expv));
        check({nm, " valid_drop"}, 32'(valid[g]), 32'(0));
    endtask

    initial begin
        int n, t1;
        logic [7:0] x, y;
        bit s;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; sm[i] = 1'b0; a[i] = '0; b[i] = '0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset busy", 32'(busy[i]), 32'(0));
            check("reset valid", 32'(valid[i]), 32'(0));
            check("reset p", 32'(p[i]), 32'(0));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(0, 1'b0, 8'd255, 8'd255, 16'hFE01, "u255x255");
        run(0, 1'b1, 8'h80, 8'h80, 16'h4000, "s-128x-128");
        run(0, 1'b1, 8'h80, 8'h7F, 16'hC080, "s-128x127");
        run(0, 1'b1, 8'hFF, 8'h01, 16'hFFFF, "s-1x1");
        run(0, 1'b0, 8'd0, 8'd77, 16'h0000, "u0x77");
        // back-to-back with start held high
        @(negedge clk);
        start[0] = 1'b1; sm[0] = 1'b0; a[0] = 8'd3; b[0] = 8'd15;
        n = 0;
        while (!valid[0] && n < 30) begin @(negedge clk); n++; end
        t1 = cyc;
        check("b2b first", 32'(p[0]), 32'(45));
        a[0] = 8'd0; b[0] = 8'd200;
        @(negedge clk);
        check("b2b reaccept busy", 32'(busy[0]), 32'(1));
        n = 0;
        while (!valid[0] && n < 30) begin @(negedge clk); n++; end
        check("b2b second", 32'(p[0]), 32'(0));
        check("b2b period", 32'(cyc - t1), 32'(9));
        start[0] = 1'b0;
        // start while busy is ignored
        @(negedge clk);
        start[0] = 1'b1; a[0] = 8'd5; b[0] = 8'd7;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        start[0] = 1'b1; a[0] = 8'd9; b[0] = 8'd9;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (!valid[0] && n < 30) begin @(negedge clk); n++; end
        check("midrun ignored", 32'(p[0]), 32'(35));
        // reset mid-run
        @(negedge clk);
        start[0] = 1'b1; a[0] = 8'd6; b[0] = 8'd6;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async rst busy", 32'(busy[0]), 32'(0));
        check("async rst valid", 32'(valid[0]), 32'(0));
        check("async rst p", 32'(p[0]), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (12) begin @(negedge clk); if (valid[0]) n++; end
        check("no valid after rst", 32'(n), 32'(0));
        // N=4 instance
        run(1, 1'b0, 8'd2, 8'd4, 16'd8, "n4 2x4");
        run(1, 1'b0, 8'd3, 8'd15, 16'd45, "n4 3x15");
        run(1, 1'b0, 8'd15, 8'd15, 16'd225, "n4 15x15");
        run(1, 1'b1, 8'h8, 8'h8, 16'h40, "n4 s-8x-8");
        for (int i = 0; i < 1000; i++) begin
            s = 1'($urandom_range(0, 1));
            x = 8'($urandom_range(0, 15));
            y = 8'($urandom_range(0, 15));
            run(1, s, x, y, exp_prod(4, s, int'(x), int'(y)), "n4 rnd");
        end
        for (int i = 0; i < 100; i++) begin
            s = 1'($urandom_range(0, 1));
            x = 8'($urandom);
            y = 8'($urandom);
            run(0, s, x, y, exp_prod(8, s, int'(x), int'(y)), "n8 rnd");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
